// File: rtl/cpu_fabric_mailbox_pkg.sv
// Shared constants for the CPU/fabric mailbox: register map, STATUS/CTRL
// bit positions and fabric word layout.
package cpu_fabric_mailbox_pkg;

  localparam logic [1:0] ADDR_TXDATA = 2'd0;
  localparam logic [1:0] ADDR_RXDATA = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  localparam int ST_TX_BUSY   = 0;
  localparam int ST_RX_EMPTY  = 1;
  localparam int ST_RX_FULL   = 2;
  localparam int ST_RX_OVF    = 3;
  localparam int ST_TX_DROP   = 4;
  localparam int ST_COUNT_LSB = 5;
  localparam int ST_COUNT_W   = 5;

  localparam int CTRL_CLR_OVF  = 0;
  localparam int CTRL_CLR_DROP = 1;
  localparam int CTRL_FLUSH    = 2;
  localparam int CTRL_IRQ_EN   = 3;

  localparam int FAB_TOGGLE    = 15;
  localparam int FAB_PAYLOAD_W = 15;

  typedef logic [FAB_PAYLOAD_W-1:0] payload_t;

endpackage

// File: rtl/cpu_fabric_mailbox_if.sv
// CPU-side register bus of the mailbox: one-cycle access strobe, registered read data.
interface cpu_fabric_mailbox_if;
  logic        bus_sel;
  logic        bus_we;
  logic [1:0]  bus_addr;
  logic [15:0] bus_wdata;
  logic [15:0] bus_rdata;

  modport master (output bus_sel, output bus_we, output bus_addr, output bus_wdata,
                  input bus_rdata);
  modport slave  (input bus_sel, input bus_we, input bus_addr, input bus_wdata,
                  output bus_rdata);
endinterface

// File: rtl/cpu_fabric_mailbox_fifo.sv
// mailbox_fifo: small synchronous FIFO with count/full/empty; a pop frees a slot
// for a same-cycle push, and flush beats any coincident push.
module mailbox_fifo #(
  parameter int WIDTH = 15,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       drop
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pop_ok, push_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok) & ~flush;
  assign drop    = push & full & ~pop_ok & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/cpu_fabric_mailbox.sv
// CPU<->fabric mailbox: toggle-qualified TX word with a busy gap, and a
// synchronized toggle receiver feeding an RX FIFO with interrupt.
module cpu_fabric_mailbox
  import cpu_fabric_mailbox_pkg::*;
#(
  parameter int RX_DEPTH    = 4,
  parameter int TX_GAP      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 CLK,
  input  logic                 resetn,
  cpu_fabric_mailbox_if.slave  bus,
  output logic                 irq,
  output logic [15:0]          fab_o,
  input  logic [15:0]          fab_i
);
  localparam int CW = $clog2(RX_DEPTH) + 1;

  logic wr_tx, wr_ctrl, rd_rx, rd_any;
  assign wr_tx   = bus.bus_sel & bus.bus_we & (bus.bus_addr == ADDR_TXDATA);
  assign wr_ctrl = bus.bus_sel & bus.bus_we & (bus.bus_addr == ADDR_CTRL);
  assign rd_any  = bus.bus_sel & ~bus.bus_we;
  assign rd_rx   = rd_any & (bus.bus_addr == ADDR_RXDATA);

  logic unused_wdata15;
  assign unused_wdata15 = bus.bus_wdata[15];

  payload_t         payload_q, payload_d;
  logic             toggle_q, toggle_d, pend_q, pend_d;
  logic [3:0]       gap_q, gap_d;
  logic             tx_busy, tx_accept;

  assign tx_busy   = pend_q | (gap_q != '0);
  assign tx_accept = wr_tx & ~tx_busy;
  assign fab_o     = {toggle_q, payload_q};

  // Payload settles one cycle ahead of the toggle so the fabric never sees a torn word.
  always_comb begin
    payload_d = payload_q;
    toggle_d  = toggle_q;
    pend_d    = pend_q;
    gap_d     = (gap_q != '0) ? gap_q - 4'd1 : gap_q;
    if (pend_q) begin
      toggle_d = ~toggle_q;
      pend_d   = 1'b0;
      gap_d    = 4'(TX_GAP);
    end
    if (tx_accept) begin
      payload_d = bus.bus_wdata[FAB_PAYLOAD_W-1:0];
      pend_d    = 1'b1;
    end
  end

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES:0]   sync_chain;
  logic                   rx_seen_q, rx_tog, rx_det;

  assign sync_chain = {sync_q, fab_i[FAB_TOGGLE]};
  assign sync_d     = sync_chain[SYNC_STAGES-1:0];
  assign rx_tog     = sync_chain[SYNC_STAGES];
  assign rx_det     = rx_tog ^ rx_seen_q;

  payload_t         fifo_rdata;
  logic [CW-1:0]    rx_count;
  logic             rx_full, rx_empty, rx_drop, flush;

  assign flush = wr_ctrl & bus.bus_wdata[CTRL_FLUSH];

  mailbox_fifo #(.WIDTH(FAB_PAYLOAD_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (CLK),
    .rst_n (resetn),
    .push  (rx_det),
    .pop   (rd_rx),
    .flush (flush),
    .wdata (fab_i[FAB_PAYLOAD_W-1:0]),
    .rdata (fifo_rdata),
    .count (rx_count),
    .full  (rx_full),
    .empty (rx_empty),
    .drop  (rx_drop)
  );

  logic        rx_ovf_q, rx_ovf_d, tx_drop_q, tx_drop_d, irq_en_q, irq_en_d, irq_q, irq_d;
  logic [15:0] rdata_q, rdata_d, status;

  assign irq           = irq_q;
  assign bus.bus_rdata = rdata_q;

  always_comb begin
    status = '0;
    status[ST_TX_BUSY]                   = tx_busy;
    status[ST_RX_EMPTY]                  = rx_empty;
    status[ST_RX_FULL]                   = rx_full;
    status[ST_RX_OVF]                    = rx_ovf_q;
    status[ST_TX_DROP]                   = tx_drop_q;
    status[ST_COUNT_LSB +: ST_COUNT_W]   = ST_COUNT_W'(rx_count);
  end

  // Clears are applied before sets so a same-cycle event is never lost.
  always_comb begin
    rx_ovf_d  = rx_ovf_q;
    tx_drop_d = tx_drop_q;
    irq_en_d  = irq_en_q;
    rdata_d   = rdata_q;
    if (wr_ctrl) begin
      if (bus.bus_wdata[CTRL_CLR_OVF])  rx_ovf_d  = 1'b0;
      if (bus.bus_wdata[CTRL_CLR_DROP]) tx_drop_d = 1'b0;
      irq_en_d = bus.bus_wdata[CTRL_IRQ_EN];
    end
    if (rx_drop)          rx_ovf_d  = 1'b1;
    if (wr_tx & tx_busy)  tx_drop_d = 1'b1;
    irq_d = irq_en_q & (~rx_empty | rx_ovf_q);
    if (rd_any) begin
      case (bus.bus_addr)
        ADDR_TXDATA: rdata_d = {1'b0, payload_q};
        ADDR_RXDATA: rdata_d = rx_empty ? 16'h0000 : {1'b0, fifo_rdata};
        ADDR_STATUS: rdata_d = status;
        default:     rdata_d = {12'h000, irq_en_q, 3'b000};
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!resetn) begin
      payload_q <= '0;
      toggle_q  <= 1'b0;
      pend_q    <= 1'b0;
      gap_q     <= '0;
      sync_q    <= '0;
      rx_seen_q <= 1'b0;
      rx_ovf_q  <= 1'b0;
      tx_drop_q <= 1'b0;
      irq_en_q  <= 1'b0;
      irq_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      payload_q <= payload_d;
      toggle_q  <= toggle_d;
      pend_q    <= pend_d;
      gap_q     <= gap_d;
      sync_q    <= sync_d;
      rx_seen_q <= rx_tog;
      rx_ovf_q  <= rx_ovf_d;
      tx_drop_q <= tx_drop_d;
      irq_en_q  <= irq_en_d;
      irq_q     <= irq_d;
      rdata_q   <= rdata_d;
    end
  end
endmodule

// File: tb/tb_cpu_fabric_mailbox.sv
// Self-checking bench for cpu_fabric_mailbox: register-access vector table plus
// hand sequences for RX fill/overflow, push-pop on full, flush and mid-gap reset.
module tb_cpu_fabric_mailbox;
  import cpu_fabric_mailbox_pkg::*;

  logic        CLK = 1'b0;
  logic        resetn = 1'b0;
  logic        irq;
  logic [15:0] fab_o;
  logic [15:0] fab_i = 16'h0000;
  logic        fab_tog = 1'b0;

  cpu_fabric_mailbox_if bus ();

  cpu_fabric_mailbox dut (
    .CLK    (CLK),
    .resetn (resetn),
    .bus    (bus),
    .irq    (irq),
    .fab_o  (fab_o),
    .fab_i  (fab_i)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       name;
    logic [15:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic        sel;
    logic        we;
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
    logic [15:0] exp_fab;
  } vec_t;
  vec_t vecs [17];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  // One clock; a read issued on this edge is scored against the queue head.
  task automatic tick();
    logic rd_issue;
    sb_t  e;
    rd_issue = bus.bus_sel & ~bus.bus_we;
    @(posedge CLK);
    #1;
    if (rd_issue) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard: read data 0x%04h with no expected entry", bus.bus_rdata);
      end else begin
        e = sb_q.pop_front();
        check(e.name, bus.bus_rdata, e.exp);
      end
    end
  endtask

  task automatic bus_wr(input logic [1:0] addr, input logic [15:0] data);
    bus.bus_sel = 1'b1; bus.bus_we = 1'b1; bus.bus_addr = addr; bus.bus_wdata = data;
    tick();
    bus.bus_sel = 1'b0; bus.bus_we = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] addr, input logic [15:0] exp, input string name);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
    bus.bus_sel = 1'b1; bus.bus_we = 1'b0; bus.bus_addr = addr;
    tick();
    bus.bus_sel = 1'b0;
  endtask

  // Leaves the toggle detected; the next edge performs the FIFO push.
  task automatic fab_arm(input logic [14:0] payload);
    fab_i = {fab_tog, payload};
    tick();
    fab_tog = ~fab_tog;
    fab_i[15] = fab_tog;
    tick();
    tick();
  endtask

  task automatic fab_send(input logic [14:0] payload);
    fab_arm(payload);
    tick();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.bus_sel = 1'b0; bus.bus_we = 1'b0; bus.bus_addr = 2'd0; bus.bus_wdata = 16'h0000;

    vecs[0]  = '{1'b1, 1'b1, ADDR_TXDATA, 16'h1234, 16'h0000, 16'h1234};
    vecs[1]  = '{1'b1, 1'b0, ADDR_STATUS, 16'h0000, 16'h0003, 16'h9234};
    vecs[2]  = '{1'b1, 1'b1, ADDR_TXDATA, 16'h5555, 16'h0000, 16'h9234};
    vecs[3]  = '{1'b1, 1'b0, ADDR_STATUS, 16'h0000, 16'h0013, 16'h9234};
    vecs[4]  = '{1'b1, 1'b0, ADDR_STATUS, 16'h0000, 16'h0013, 16'h9234};
    vecs[5]  = '{1'b1, 1'b0, ADDR_STATUS, 16'h0000, 16'h0013, 16'h9234};
    vecs[6]  = '{1'b1, 1'b0, ADDR_STATUS, 16'h0000, 16'h0012, 16'h9234};
    vecs[7]  = '{1'b1, 1'b1, ADDR_CTRL,   16'h0002, 16'h0000, 16'h9234};
    vecs[8]  = '{1'b1, 1'b0, ADDR_STATUS, 16'h0000, 16'h0002, 16'h9234};
    vecs[9]  = '{1'b1, 1'b0, ADDR_TXDATA, 16'h0000, 16'h1234, 16'h9234};
    vecs[10] = '{1'b1, 1'b1, ADDR_STATUS, 16'hFFFF, 16'h0000, 16'h9234};
    vecs[11] = '{1'b1, 1'b0, ADDR_STATUS, 16'h0000, 16'h0002, 16'h9234};
    vecs[12] = '{1'b1, 1'b0, ADDR_RXDATA, 16'h0000, 16'h0000, 16'h9234};
    vecs[13] = '{1'b1, 1'b0, ADDR_CTRL,   16'h0000, 16'h0000, 16'h9234};
    vecs[14] = '{1'b1, 1'b1, ADDR_TXDATA, 16'h8ABC, 16'h0000, 16'h8ABC};
    vecs[15] = '{1'b0, 1'b0, ADDR_TXDATA, 16'h0000, 16'h0000, 16'h0ABC};
    vecs[16] = '{1'b1, 1'b0, ADDR_TXDATA, 16'h0000, 16'h0ABC, 16'h0ABC};

    tick();
    tick();
    check("rst_fab_o", fab_o, 16'h0000);
    check("rst_irq", {15'h0, irq}, 16'h0000);
    check("rst_rdata", bus.bus_rdata, 16'h0000);
    resetn = 1'b1;
    tick();
    bus_rd(ADDR_STATUS, 16'h0002, "rst_status");

    for (int i = 0; i < 17; i++) begin
      sb_t e;
      bus.bus_sel = vecs[i].sel; bus.bus_we = vecs[i].we;
      bus.bus_addr = vecs[i].addr; bus.bus_wdata = vecs[i].wdata;
      if (vecs[i].sel && !vecs[i].we) begin
        e.name = $sformatf("vec%0d_rdata", i);
        e.exp  = vecs[i].exp_rd;
        sb_q.push_back(e);
      end
      tick();
      check($sformatf("vec%0d_fab_o", i), fab_o, vecs[i].exp_fab);
    end
    bus.bus_sel = 1'b0; bus.bus_we = 1'b0;
    repeat (6) tick();

    for (int p = 1; p <= 4; p++) fab_send(15'(p));
    bus_rd(ADDR_STATUS, 16'h0084, "fill_status");
    for (int p = 1; p <= 4; p++) bus_rd(ADDR_RXDATA, 16'(p), $sformatf("fill_rx%0d", p));
    bus_rd(ADDR_STATUS, 16'h0002, "drain_status");
    bus_rd(ADDR_RXDATA, 16'h0000, "empty_read");
    bus_rd(ADDR_STATUS, 16'h0002, "empty_read_status");

    bus_wr(ADDR_CTRL, 16'h0008);
    for (int p = 16'h11; p <= 16'h15; p++) fab_send(15'(p));
    bus_rd(ADDR_STATUS, 16'h008C, "ovf_status");
    check("ovf_irq", {15'h0, irq}, 16'h0001);
    bus_wr(ADDR_CTRL, 16'h0009);
    bus_rd(ADDR_STATUS, 16'h0084, "ovf_cleared_status");
    fab_arm(15'h0016);
    bus_rd(ADDR_RXDATA, 16'h0011, "full_pushpop_rx");
    bus_rd(ADDR_STATUS, 16'h0084, "full_pushpop_status");
    bus_rd(ADDR_RXDATA, 16'h0012, "pp_rx_a");
    bus_rd(ADDR_RXDATA, 16'h0013, "pp_rx_b");
    bus_rd(ADDR_RXDATA, 16'h0014, "pp_rx_c");
    bus_rd(ADDR_RXDATA, 16'h0016, "pp_rx_d");
    bus_rd(ADDR_STATUS, 16'h0002, "pp_empty_status");
    check("empty_irq", {15'h0, irq}, 16'h0000);

    fab_send(15'h0031);
    fab_arm(15'h0032);
    bus_wr(ADDR_CTRL, 16'h0004);
    bus_rd(ADDR_STATUS, 16'h0002, "flush_push_status");

    bus_wr(ADDR_CTRL, 16'h0008);
    fab_send(15'h0021);
    fab_send(15'h0022);
    bus_rd(ADDR_STATUS, 16'h0040, "pre_rst_status");
    check("pre_rst_irq", {15'h0, irq}, 16'h0001);
    bus_wr(ADDR_TXDATA, 16'h7777);
    tick();
    tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    check("midgap_rst_fab_o", fab_o, 16'h0000);
    check("midgap_rst_irq", {15'h0, irq}, 16'h0000);
    check("midgap_rst_rdata", bus.bus_rdata, 16'h0000);
    bus_rd(ADDR_STATUS, 16'h0002, "midgap_rst_status");
    bus_rd(ADDR_CTRL, 16'h0000, "midgap_rst_ctrl");
    repeat (4) tick();
    bus_rd(ADDR_STATUS, 16'h0002, "post_rst_no_spurious");

    check("scoreboard_drained", 16'(sb_q.size()), 16'h0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cpu_fabric_mailbox.md
CPU_FABRIC_MAILBOX -- requirements
Module: cpu_fabric_mailbox

Interface
REQ-001 The block SHALL have parameter RX_DEPTH, default 4, RX FIFO entries (power of two, 2..16).
REQ-002 The block SHALL have parameter TX_GAP, default 4, minimum cycles between TX toggles (2..15).
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2, synchronizer depth on fab_i[15].
REQ-004 The block SHALL have port CLK, input, 1, the single clock; all state is on the rising edge.
REQ-005 The block SHALL have port resetn, input, 1, reset that is synchronous and active-low.
REQ-006 The block SHALL have port bus_sel, input, 1, bus access strobe, one cycle per access.
REQ-007 The block SHALL have port bus_we, input, 1, 1 = write, 0 = read.
REQ-008 The block SHALL have port bus_addr, input, 2, register select: 0 TXDATA, 1 RXDATA, 2 STATUS, 3 CTRL.
REQ-009 The block SHALL have port bus_wdata, input, 16, write data.
REQ-010 The block SHALL have port bus_rdata, output, 16, registered read data, valid the cycle after a read access.
REQ-011 The block SHALL have port irq, output, 1, RX interrupt.
REQ-012 The block SHALL have port fab_o, output, 16, to the fabric-facing O_top: [15] TX toggle, [14:0] TX payload.
REQ-013 The block SHALL have port fab_i, input, 16, from the fabric-facing I_top: [15] RX toggle, [14:0] RX payload.

Function
REQ-014 A TXDATA write with tx_busy=0 SHALL load fab_o[14:0]=bus_wdata[14:0] in the next cycle, invert fab_o[15] one cycle later, and set tx_busy.
REQ-015 tx_busy SHALL remain 1 for TX_GAP cycles after the toggle edge, via a down-counter; a TXDATA write while busy SHALL be dropped and set the sticky tx_drop flag.
REQ-016 fab_o[14:0] SHALL stay stable from the payload load until the next accepted write.
REQ-017 fab_i[15] SHALL pass through SYNC_STAGES flops; fab_i[14:0] SHALL be sampled when the synchronized toggle differs from the last-seen toggle (fabric holds payload stable from at least 1 cycle before the toggle until the next toggle).
REQ-018 On each detected toggle the payload SHALL be pushed into the RX FIFO; if the FIFO is full, the word SHALL be discarded and the sticky rx_ovf flag set.
REQ-019 A RXDATA read SHALL return {1'b0, head} and pop when non-empty; a read when empty SHALL return 0 with no pop.
REQ-020 A simultaneous push and pop on a full FIFO SHALL succeed without overflow; on an empty FIFO the pop SHALL return 0 and the push SHALL land.
REQ-021 STATUS SHALL read [0] tx_busy, [1] rx_empty, [2] rx_full, [3] rx_ovf, [4] tx_drop, [9:5] rx_count, with all other bits 0.
REQ-022 A CTRL write SHALL apply: [0] clear rx_ovf, [1] clear tx_drop, [2] flush RX FIFO (one cycle), [3] irq_en (stored); a CTRL read SHALL return irq_en in [3] and 0 elsewhere.
REQ-023 irq SHALL be registered and equal irq_en AND (NOT rx_empty OR rx_ovf).
REQ-024 A flush coincident with a push SHALL leave the FIFO empty, with the push lost.
REQ-025 Reads of TXDATA SHALL return the current fab_o[14:0]; writes to RXDATA and STATUS SHALL be ignored.

Reset
REQ-026 On resetn=0 at CLK, fab_o SHALL go to 0 and tx_busy, the gap counter, FIFO pointers, rx_count, rx_ovf, tx_drop, irq_en, irq and bus_rdata SHALL all go to 0.
REQ-027 The last-seen RX toggle and synchronizer flops SHALL reset to 0, and the first post-reset cycles SHALL NOT register a spurious toggle if fab_i[15]=0.
REQ-028 Reset in mid-gap or mid-transfer SHALL abort it with no partial push.

Structure
REQ-029 A shared package SHALL hold the register address constants, the STATUS/CTRL bit positions and the fab word field positions.
REQ-030 The RX FIFO SHALL be the sub-module mailbox_fifo (parameterized width/depth, with count, full and empty).

Verification
REQ-031 A bench SHALL cover: write TXDATA 0x1234 -> fab_o[14:0]=0x1234 at +1, fab_o[15] 0->1 at +2, tx_busy=1 for 4 cycles, then 0.
REQ-032 A bench SHALL cover: second TXDATA write 2 cycles after the first -> fab_o unchanged, STATUS[4]=1; CTRL write 0x2 -> STATUS[4]=0.
REQ-033 A bench SHALL cover: fabric toggles with payloads 0x0001..0x0004 -> rx_count=4, rx_full=1, reads return 0x0001..0x0004 in order.
REQ-034 A bench SHALL cover: five fabric toggles without reads -> fifth word lost, STATUS[3]=1; with irq_en=1, irq=1.
REQ-035 A bench SHALL cover: read RXDATA when empty -> 0x0000, rx_count stays 0; simultaneous push and pop when full -> count stays 4, no overflow.
REQ-036 A bench SHALL cover: resetn low during the TX gap with 2 RX words queued -> fab_o=0, STATUS=0x0002, irq=0.
